// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and helpers for the execute unit and the ALU decoder.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_SLL  = 4'h2,
      ALU_SLT  = 4'h3,
      ALU_SLTU = 4'h4,
      ALU_XOR  = 4'h5,
      ALU_SRA  = 4'h6,
      ALU_SRL  = 4'h7,
      ALU_OR   = 4'h8,
      ALU_AND  = 4'h9,
      ALU_EQ   = 4'ha,
      ALU_NE   = 4'hb,
      ALU_GE   = 4'hc,
      ALU_GEU  = 4'hd
   } alu_op_e;

   localparam logic [3:0] ALU_UNDEF = 4'hf;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops; shift codes return 0 here because the FSM iterates them.
module alu_comb
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_result,
   output logic            o_illegal
);

   logic signed [XLEN-1:0] w_as;
   logic signed [XLEN-1:0] w_bs;
   logic [XLEN-1:0]        w_res;
   logic                   w_illegal;

   assign w_as = i_a;
   assign w_bs = i_b;

   always_comb begin
      w_res     = '0;
      w_illegal = 1'b0;
      case (i_op)
         ALU_ADD:  w_res = i_a + i_b;
         ALU_SUB:  w_res = i_a - i_b;
         ALU_SLT:  w_res = {{(XLEN-1){1'b0}}, (w_as < w_bs)};
         ALU_SLTU: w_res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
         ALU_XOR:  w_res = i_a ^ i_b;
         ALU_OR:   w_res = i_a | i_b;
         ALU_AND:  w_res = i_a & i_b;
         ALU_EQ:   w_res = {{(XLEN-1){1'b0}}, (i_a == i_b)};
         ALU_NE:   w_res = {{(XLEN-1){1'b0}}, (i_a != i_b)};
         ALU_GE:   w_res = {{(XLEN-1){1'b0}}, (w_as >= w_bs)};
         ALU_GEU:  w_res = {{(XLEN-1){1'b0}}, (i_a >= i_b)};
         ALU_SLL, ALU_SRA, ALU_SRL: w_res = '0;
         default:  w_illegal = 1'b1;
      endcase
   end

   assign o_result  = w_res;
   assign o_illegal = w_illegal;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute unit: single-cycle ALU ops plus bit-serial shifts behind a valid/ready handshake.
module seq_alu
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      aluControl,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            taken,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);

   state_e          r_state;
   logic [XLEN-1:0] r_result;
   logic            r_illegal;
   logic [XLEN-1:0] r_shreg;
   logic [SHW-1:0]  r_cnt;
   logic [3:0]      r_op;

   logic [XLEN-1:0] w_comb_res;
   logic            w_comb_ill;
   logic [XLEN-1:0] w_shift_nxt;
   logic            w_accept;

   alu_comb #(.XLEN(XLEN)) u_alu_comb (
      .i_op      (aluControl),
      .i_a       (a),
      .i_b       (b),
      .o_result  (w_comb_res),
      .o_illegal (w_comb_ill)
   );

   assign w_accept = in_valid && (r_state == ST_IDLE);

   always_comb begin
      w_shift_nxt = r_shreg;
      case (r_op)
         ALU_SLL: w_shift_nxt = {r_shreg[XLEN-2:0], 1'b0};
         ALU_SRL: w_shift_nxt = {1'b0, r_shreg[XLEN-1:1]};
         ALU_SRA: w_shift_nxt = {r_shreg[XLEN-1], r_shreg[XLEN-1:1]};
         default: w_shift_nxt = r_shreg;
      endcase
   end

   // Shift datapath carries no reset; it is only observed while in SHIFT.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_shreg <= a;
         r_cnt   <= b[SHW-1:0];
         r_op    <= aluControl;
      end else if (r_state == ST_SHIFT) begin
         r_shreg <= w_shift_nxt;
         r_cnt   <= r_cnt - SHW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_result  <= '0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_illegal <= w_comb_ill;
                  if (is_shift_op(aluControl)) begin
                     if (b[SHW-1:0] == '0) begin
                        r_result <= a;
                        r_state  <= ST_DONE;
                     end else begin
                        r_state  <= ST_SHIFT;
                     end
                  end else begin
                     r_result <= w_comb_res;
                     r_state  <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               // Counter holds the shifts still pending, including this one.
               if (r_cnt == SHW'(1)) begin
                  r_result <= w_shift_nxt;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign result    = r_result;
   assign zero      = (r_result == '0);
   assign taken     = r_result[0];
   assign illegal   = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu: reset, wrap, compares, iterative shifts, undefined op and back-to-back.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  aluControl = 4'h0;
   logic [31:0] a = 32'h0;
   logic [31:0] b = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic        taken;
   logic        illegal;

   int vectors = 0;
   int miscompares = 0;

   seq_alu #(.XLEN(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .aluControl (aluControl),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero       (zero),
      .taken      (taken),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic do_op(input logic [3:0] code, input logic [31:0] va, input logic [31:0] vb,
                        output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      aluControl = code; a = va; b = vb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      vectors++;
      if ({result, zero, taken, illegal, out_valid} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_outputs: got res=%h z=%b t=%b ill=%b ov=%b want 0/1/0/0/0",
                  result, zero, taken, illegal, out_valid);
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add_wrap();
      int lat;
      do_op(4'h0, 32'hFFFF_FFFF, 32'h1, lat);
      vectors++;
      if (lat !== 1) begin miscompares++; $display("FAIL add_latency: got %0d want 1", lat); end
      vectors++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         miscompares++;
         $display("FAIL add_wrap: got res=%h z=%b want 00000000/1", result, zero);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (result !== 32'h0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL add_hold%0d: got res=%h ov=%b ir=%b want 0/1/0", i, result, out_valid, in_ready);
         end
      end
      pop();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL add_release: got ir=%b ov=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_signed_unsigned();
      int lat;
      do_op(4'h3, 32'hFFFF_FFFE, 32'h1, lat);
      vectors++;
      if (result !== 32'h1 || taken !== 1'b1) begin
         miscompares++; $display("FAIL slt: got res=%h t=%b want 00000001/1", result, taken);
      end
      pop();
      do_op(4'h4, 32'hFFFF_FFFE, 32'h1, lat);
      vectors++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         miscompares++; $display("FAIL sltu: got res=%h z=%b want 00000000/1", result, zero);
      end
      pop();
      do_op(4'hc, 32'hFFFF_FFFE, 32'h1, lat);
      vectors++;
      if (taken !== 1'b0) begin miscompares++; $display("FAIL ge: got t=%b want 0", taken); end
      pop();
      do_op(4'hd, 32'hFFFF_FFFE, 32'h1, lat);
      vectors++;
      if (taken !== 1'b1 || result !== 32'h1) begin
         miscompares++; $display("FAIL geu: got res=%h t=%b want 00000001/1", result, taken);
      end
      pop();
   endtask

   task automatic test_shift();
      int lat;
      do_op(4'h6, 32'h8000_0000, 32'd31, lat);
      vectors++;
      if (lat !== 32) begin miscompares++; $display("FAIL sra_latency: got %0d want 32", lat); end
      vectors++;
      if (result !== 32'hFFFF_FFFF) begin
         miscompares++; $display("FAIL sra_result: got %h want ffffffff", result);
      end
      pop();
      do_op(4'h7, 32'h8000_0000, 32'd31, lat);
      vectors++;
      if (lat !== 32 || result !== 32'h1) begin
         miscompares++; $display("FAIL srl: got lat=%0d res=%h want 32/00000001", lat, result);
      end
      pop();
      do_op(4'h2, 32'h8000_0000, 32'h20, lat);
      vectors++;
      if (lat !== 1 || result !== 32'h8000_0000) begin
         miscompares++; $display("FAIL sll_shamt0: got lat=%0d res=%h want 1/80000000", lat, result);
      end
      pop();
      do_op(4'h2, 32'h0000_0003, 32'hFFFF_FFE4, lat);
      vectors++;
      if (lat !== 5 || result !== 32'h30) begin
         miscompares++; $display("FAIL sll_4: got lat=%0d res=%h want 5/00000030", lat, result);
      end
      pop();
   endtask

   task automatic test_undef_back_to_back();
      int lat;
      int acc;
      int outs;
      do_op(4'hf, 32'h5, 32'h5, lat);
      vectors++;
      if (lat !== 1 || result !== 32'h0 || illegal !== 1'b1) begin
         miscompares++;
         $display("FAIL undef: got lat=%0d res=%h ill=%b want 1/00000000/1", lat, result, illegal);
      end
      pop();
      do_op(4'ha, 32'h5, 32'h5, lat);
      vectors++;
      if (taken !== 1'b1 || illegal !== 1'b0) begin
         miscompares++; $display("FAIL eq_after_undef: got t=%b ill=%b want 1/0", taken, illegal);
      end
      pop();
      acc = 0; outs = 0;
      @(negedge clk);
      aluControl = 4'h0; a = 32'h1; b = 32'h2; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         if (in_ready) acc++;
         if (out_valid) begin
            outs++;
            vectors++;
            if (result !== 32'h3 || in_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_result%0d: got res=%h ir=%b want 00000003/0", i, result, in_ready);
            end
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      vectors++;
      if (acc !== 6 || outs !== 6) begin
         miscompares++; $display("FAIL b2b_accepts: got acc=%0d outs=%0d want 6/6", acc, outs);
      end
   endtask

   task automatic test_reset_mid_op();
      int ovs;
      aluControl = 4'h2; a = 32'h1; b = 32'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL mid_shift_busy: got ir=%b ov=%b want 0/0", in_ready, out_valid);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if ({result, zero, taken, illegal, out_valid} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: got res=%h z=%b t=%b ill=%b ov=%b want 0/1/0/0/0",
                  result, zero, taken, illegal, out_valid);
      end
      @(negedge clk); reset_n = 1'b1;
      ovs = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid) ovs++;
      end
      vectors++;
      if (ovs !== 0 || in_ready !== 1'b1) begin
         miscompares++; $display("FAIL mid_reset_discard: got ov_cycles=%0d ir=%b want 0/1", ovs, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_signed_unsigned();
      test_shift();
      test_undef_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle execute unit directly downstream of the ALU decoder.
- Consumes the decoder's 4-bit aluControl code and two operands, then returns a result and a branch-taken flag over a valid/ready handshake.
- Shifts are iterative, one bit per cycle; all other ops complete in one cycle.
- Lets the core move to a multi-cycle datapath without a barrel shifter.

Parameters:
- XLEN, 32, operand/result width; shift amount is b[$clog2(XLEN)-1:0].

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept (high only in IDLE)
- aluControl  input  4  op code from decoder
- a  input  XLEN  operand A (rs1)
- b  input  XLEN  operand B (rs2 or immediate)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  registered result
- zero  output  1  result == 0
- taken  output  1  branch condition true (result[0])
- illegal  output  1  undefined code was executed

Behaviour:
- Op codes, fixed and shared with the decoder:
  - 0 add, 1 sub, 2 sll, 3 slt (signed), 4 sltu, 5 xor
  - 6 sra, 7 srl, 8 or, 9 and
  - a eq, b ne, c ge (signed), d geu
  - e and f undefined
- Compare ops (3, 4, a–d) produce {XLEN-1 zeros, cond}.
- add/sub wrap modulo 2^XLEN; no overflow flag.
- Undefined code: result 0, illegal 1, latency 1.
- States are IDLE, SHIFT, DONE.
- Reset (async, reset_n low): state IDLE; result 0, zero 1, taken 0, illegal 0, out_valid 0; in_ready 1 after release. Reset mid-SHIFT or mid-DONE discards the op with no output.
- Accept: in_valid & in_ready at edge k; operands and code are captured at that edge.
- Non-shift op: result registered at edge k; DONE and out_valid=1 from cycle k+1.
- Shift op (2, 6, 7), shamt n = b[4:0] for XLEN=32:
  - Capture a into shift register, counter=n.
  - n==0: DONE at k+1, result=a.
  - n>0: enter SHIFT; each cycle shift 1 bit (sll: zero in at LSB; srl: zero in at MSB; sra: sign bit replicated) and decrement counter; counter==1 → DONE.
  - out_valid first high at cycle k+n+1.
- b[XLEN-1:5] is ignored for shifts.
- DONE: result, zero, taken, illegal are stable while out_valid & !out_ready.
- out_valid & out_ready at an edge → IDLE. in_ready rises the next cycle; there is no accept in DONE.
- in_valid while busy is ignored; in_ready is 0, so the producer must hold.
- zero/taken/illegal are derived from the registered result, so there is no comb path from inputs to outputs.
- in_ready is a pure function of state.
- illegal clears on the next accepted op.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum for codes 0x0–0xd
  - ALU_UNDEF = 4'hf
  - is_shift_op() function
  - state enum for IDLE/SHIFT/DONE
- The decoder switches to alu_pkg constants.
- One sub-module, alu_comb: the purely combinational single-cycle ops (add through geu except shifts). seq_alu owns the FSM, shift register and counter.

Test Plan:
- Reset mid-op: assert reset_n low during SHIFT with n=20 → outputs immediately return to reset values, in_ready=1 after release, no out_valid.
- Add wrap: a=0xFFFF_FFFF, b=1, code 0 → out_valid at k+1, result 0, zero=1; out_ready held low 3 cycles → result stable, in_ready=0.
- Signed vs unsigned: a=0xFFFF_FFFE, b=1 → code 3 result 1, taken=1; code 4 result 0; code c taken=0; code d taken=1.
- Iterative sra: a=0x8000_0000, b=31, code 6 → out_valid first at k+32, result 0xFFFF_FFFF. Same operands with code 7 → result 1. b=0x20 (shamt 0), code 2 → out_valid at k+1, result=a.
- Undefined and back-to-back: code f → result 0, illegal=1. Next op code a with a=b=5 → taken=1, illegal=0. in_valid held high throughout → exactly one accept per IDLE visit.
